adder_rr_scheduler: RTL and testbench



---
 rtl/adder_rr_pkg.sv | 20 ++
 rtl/adder_rr_scheduler_rr_arbiter.sv | 42 ++++
 rtl/adder_rr_scheduler.sv | 147 ++++++++++++++
 tb/tb_adder_rr_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_rr_pkg.sv
// Shared definitions for the round-robin adder scheduler.
//   state_e    : response-slot state (EMPTY / FULL)
//   DEF_NREQ   : default requester count
//   DEF_W      : default operand width
//   idx_width  : width of a requester index for a given requester count
package adder_rr_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i   [NREQ]  request vector
//   ptr_i   [IDW]   highest-priority index for this cycle
//   en_i            grant enable (gnt_o is forced to zero when low)
//   gnt_o   [NREQ]  one-hot grant, or zero
//   idx_o   [IDW]   index of the first requester found from ptr_i
//   found_o         at least one request is present
module rr_arbiter
  import adder_rr_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            found_o
);

  int j;

  // Search ptr, ptr+1, ... wrapping; first hit wins. idx_o is valid
  // regardless of en_i so the operand mux can settle early.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!found_o && req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDW'(j);
      end
    end
    if (found_o && en_i) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one W-bit adder among NREQ requesters in round-robin order and
// registers the winner's result into a one-entry response slot.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready[NREQ] request handshake (ready is one-hot or zero)
//   req_a, req_b [NREQ*W]    operands, requester i at [i*W +: W]
//   req_cin [NREQ]           carry-in
//   req_lock [NREQ]          chain lock (only with ADDER_RR_CHAIN_EN)
//   rsp_valid/rsp_ready      response handshake
//   rsp_sum, rsp_cout, rsp_id registered result and requester tag
//   dbg_state_o              response-slot state, for observation
// Optional feature macro: ADDER_RR_CHAIN_EN (multi-word carry chaining).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid must not depend on ready; ready may depend on valid. Here
// req_ready[i] is high only if req_valid[i] is high, requester i wins the
// round-robin search, and the slot is empty or being drained this cycle.
module adder_rr_scheduler
  import adder_rr_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  parameter  int W    = DEF_W,
  localparam int IDW  = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0] req_cin,
`ifdef ADDER_RR_CHAIN_EN
  input  logic [NREQ-1:0] req_lock,
`endif
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_sum,
  output logic            rsp_cout,
  output logic [IDW-1:0]  rsp_id,
  output state_e          dbg_state_o
);

  state_e         state_q, state_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] arb_ptr, win, ptr_next;
  logic           slot_free, found, xfer, cin_sel;
  logic [W-1:0]   a_sel, b_sel;
  logic [W:0]     add_res;

  assign slot_free = (state_q == EMPTY) | rsp_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (arb_ptr),
    .en_i    (slot_free),
    .gnt_o   (req_ready),
    .idx_o   (win),
    .found_o (found)
  );

  assign xfer     = found & slot_free;
  assign ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

`ifdef ADDER_RR_CHAIN_EN
  logic           chain_q, chain_d;
  logic [IDW-1:0] chain_id_q, chain_id_d;

  // A locked requester outranks the round-robin pointer, and its next add
  // continues from the carry held in the response slot.
  assign arb_ptr = chain_q ? chain_id_q : ptr_q;
  assign cin_sel = (chain_q && (win == chain_id_q)) ? cout_q : req_cin[win];
`else
  assign arb_ptr = ptr_q;
  assign cin_sel = req_cin[win];
`endif

  assign a_sel   = req_a[int'(win)*W +: W];
  assign b_sel   = req_b[int'(win)*W +: W];
  assign add_res = {1'b0, a_sel} + {1'b0, b_sel} + {{W{1'b0}}, cin_sel};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef ADDER_RR_CHAIN_EN
    chain_d    = chain_q;
    chain_id_d = chain_id_q;
`endif
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (!xfer && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    // Data registers only change on accept; a plain drain leaves them as-is.
    if (xfer) begin
      sum_d  = add_res[W-1:0];
      cout_d = add_res[W];
      id_d   = win;
      ptr_d  = ptr_next;
`ifdef ADDER_RR_CHAIN_EN
      if (req_lock[win]) begin
        chain_d    = 1'b1;
        chain_id_d = win;
        ptr_d      = ptr_q;
      end else if (chain_q && (win == chain_id_q)) begin
        chain_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef ADDER_RR_CHAIN_EN
      chain_q    <= 1'b0;
      chain_id_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef ADDER_RR_CHAIN_EN
      chain_q    <= chain_d;
      chain_id_q <= chain_id_d;
`endif
    end
  end

  assign rsp_valid   = (state_q == FULL);
  assign rsp_sum     = sum_q;
  assign rsp_cout    = cout_q;
  assign rsp_id      = id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler (NREQ=4, W=8).
module tb_adder_rr_scheduler;
  import adder_rr_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0] req_cin = '0;
`ifdef ADDER_RR_CHAIN_EN
  logic [NREQ-1:0] req_lock = '0;
`endif
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic [1:0]      rsp_id;
  state_e          dbg_state;

  adder_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_cin     (req_cin),
`ifdef ADDER_RR_CHAIN_EN
    .req_lock    (req_lock),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_sum     (rsp_sum),
    .rsp_cout    (rsp_cout),
    .rsp_id      (rsp_id),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Slot contents and round-robin pointer as plain integers.
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_sum;
  logic       m_cout;
  int         m_id;

  function automatic int pick(input logic [3:0] v, input int ptr, input bit free);
    if (!free) return -1;
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_sum = '0; m_cout = 0; m_id = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_cin = '0;
`ifdef ADDER_RR_CHAIN_EN
    req_lock = '0;
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Inputs already driven (just after an edge). Checks ready, clocks once,
  // advances the model and checks the registered response.
  task automatic cycle(input string tag);
    int g, s;
    logic [3:0] exp_rdy;
    #1;
    g = pick(req_valid, m_ptr, !m_valid || rsp_ready);
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      s = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]) + int'(req_cin[g]);
      m_sum   = 8'(s % 256);
      m_cout  = (s >= 256);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NREQ;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(m_valid));
    chk({tag, ".state"}, 32'(dbg_state), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".sum"},  32'(rsp_sum),  32'(m_sum));
      chk({tag, ".cout"}, 32'(rsp_cout), 32'(m_cout));
      chk({tag, ".id"},   32'(rsp_id),   32'(m_id));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
    vecs[1] = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[3] = '{3, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    // Reset values
    reset_dut();
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.sum",   32'(rsp_sum),   32'd0);
    chk("rst.cout",  32'(rsp_cout),  32'd0);
    chk("rst.id",    32'(rsp_id),    32'd0);

    // Requester 2 alone: F0 + 20
    set_req(2, 8'hF0, 8'h20, 1'b0);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    cycle("single");
    chk("single.sum_k",  32'(rsp_sum),  32'h10);
    chk("single.cout_k", 32'(rsp_cout), 32'd1);
    chk("single.id_k",   32'(rsp_id),   32'd2);
    req_valid = '0;
    cycle("drain");

    // All requesting, sink always ready: strict 0,1,2,3 order
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 16), 8'(i + 1), i[0]);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle("rr");
      chk("rr.order", 32'(rsp_id), 32'(k % NREQ));
    end

    // Backpressure for 5 cycles: no grants, slot stable
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle("hold");
      chk("hold.id_k", 32'(rsp_id), 32'd3);
    end
    rsp_ready = 1'b1;
    cycle("release");
    chk("release.id_k", 32'(rsp_id), 32'd0);

    // Table-driven arithmetic corners
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].cin);
      req_valid = 4'(1 << vecs[v].idx);
      rsp_ready = 1'b1;
      cycle("vec");
      chk("vec.sum_k",  32'(rsp_sum),  32'(vecs[v].sum));
      chk("vec.cout_k", 32'(rsp_cout), 32'(vecs[v].cout));
      chk("vec.id_k",   32'(rsp_id),   32'(vecs[v].idx));
    end

    // Reset with slot full and pointer at 3
    reset_dut();
    set_req(2, 8'h11, 8'h22, 1'b0);
    req_valid = 4'b0100; rsp_ready = 1'b0;
    cycle("prerst");
    rst = 1'b1; req_valid = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst.valid", 32'(rsp_valid), 32'd0);
    #1;
    chk("midrst.ready", 32'(req_ready), 32'b0001);
    cycle("postrst");

    // Randomized traffic against the model
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = $urandom;
      req_b     = $urandom;
      req_cin   = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

`ifdef ADDER_RR_CHAIN_EN
    // Two-word add on requester 1: FF+01 then 00+00 with carry chained
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h05, 8'h05, 1'b0);
    set_req(1, 8'hFF, 8'h01, 1'b0);
    req_valid = 4'b0010; req_lock = 4'b0010; rsp_ready = 1'b1;
    #1;
    chk("chain0.ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    chk("chain0.sum",  32'(rsp_sum),  32'h00);
    chk("chain0.cout", 32'(rsp_cout), 32'd1);
    chk("chain0.id",   32'(rsp_id),   32'd1);
    set_req(1, 8'h00, 8'h00, 1'b0);
    req_valid = 4'b1111; req_lock = 4'b0000;
    #1;
    chk("chain1.ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    chk("chain1.valid", 32'(rsp_valid), 32'd1);
    chk("chain1.sum",   32'(rsp_sum),   32'h01);
    chk("chain1.cout",  32'(rsp_cout),  32'd0);
    chk("chain1.id",    32'(rsp_id),    32'd1);
    #1;
    chk("chain2.ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    chk("chain2.id",    32'(rsp_id),    32'd2);
    reset_dut();
`endif

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
